if_fetch_unit: RTL and testbench

//  IF stage: owns the PC, drives a req/ack instruction-RAM port, presents {pc_o, inst_o, excepttype_o}
//  to the IF/ID register. Raises stallreq_o until the fetched word is held, so the stall controller

---
 rtl/if_fetch_unit_if.sv | 21 ++
 rtl/if_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-RAM request/acknowledge port between the IF stage (master) and the instruction memory (slave).
interface if_fetch_unit_if;
  logic        iram_req_o;
  logic [31:0] iram_addr_o;
  logic        iram_ack_i;
  logic [31:0] iram_rdata_i;

  modport master (
    output iram_req_o,
    output iram_addr_o,
    input  iram_ack_i,
    input  iram_rdata_i
  );

  modport slave (
    input  iram_req_o,
    input  iram_addr_o,
    output iram_ack_i,
    output iram_rdata_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: PC owner, req/ack instruction fetch, flush/branch redirect with one delay slot, stale-ack drop.
// Optional macro IF_MISALIGN_EXC_EN: a misaligned PC is not fetched and raises excepttype_o[ADEL_BIT].
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          ADEL_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      stall,
  input  logic            flush,
  input  logic [31:0]     new_pc,
  input  logic            branch_flag_i,
  input  logic [31:0]     branch_target_address_i,
  output logic            stallreq_o,
  if_fetch_unit_if.master iram,
  output logic [31:0]     pc_o,
  output logic [31:0]     inst_o,
  output logic [31:0]     excepttype_o
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_REQ     = 2'd1;
  localparam logic [1:0]  S_VALID   = 2'd2;
  localparam logic [1:0]  S_DISCARD = 2'd3;
  localparam logic [31:0] ADEL_MASK = 32'd1 << ADEL_BIT;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic        r_pend;
  logic [31:0] r_ptgt;
  logic [31:0] r_stale_addr;
  logic        r_adel;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_buf_nxt;
  logic        w_pend_nxt;
  logic [31:0] w_ptgt_nxt;
  logic [31:0] w_stale_nxt;
  logic        w_adel_nxt;

  logic        w_branch;
  logic        w_advance;
  logic [31:0] w_next_pc;
  logic        w_misalign;
  logic [31:0] w_fetch_addr;
  logic        w_unused;

`ifdef IF_MISALIGN_EXC_EN
  assign w_misalign   = (r_pc[1:0] != 2'b00);
  assign w_fetch_addr = r_pc;
`else
  assign w_misalign   = 1'b0;
  assign w_fetch_addr = {r_pc[31:2], 2'b00};
`endif

  assign w_branch  = branch_flag_i && !stall[2];
  assign w_advance = (r_state == S_VALID) && !stall[0];
  assign w_next_pc = w_branch ? branch_target_address_i
                   : (r_pend ? r_ptgt : r_pc + 32'd4);
  assign w_unused  = ^{stall[5:3], stall[1]};

  // Next-state, PC redirect and delay-slot bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_pend_nxt  = r_pend;
    w_ptgt_nxt  = r_ptgt;
    w_stale_nxt = r_stale_addr;
    w_adel_nxt  = r_adel;
    if (flush) begin
      w_pc_nxt   = new_pc;
      w_pend_nxt = 1'b0;
      w_adel_nxt = 1'b0;
      case (r_state)
        S_REQ: begin
          // An outstanding request must still be acked, so remember its address
          if (iram.iram_ack_i || w_misalign) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DISCARD;
            w_stale_nxt = w_fetch_addr;
          end
        end
        S_DISCARD: begin
          if (iram.iram_ack_i) w_state_nxt = S_REQ;
          else                 w_state_nxt = S_DISCARD;
        end
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (w_misalign) begin
            w_state_nxt = S_VALID;
            w_buf_nxt   = NOP_INST;
            w_adel_nxt  = 1'b1;
          end else if (iram.iram_ack_i) begin
            w_state_nxt = S_VALID;
            w_buf_nxt   = iram.iram_rdata_i;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
        S_VALID: begin
          if (w_advance) begin
            w_state_nxt = S_REQ;
            w_pc_nxt    = w_next_pc;
            w_pend_nxt  = 1'b0;
            w_adel_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_VALID;
          end
        end
        S_DISCARD: begin
          if (iram.iram_ack_i) w_state_nxt = S_REQ;
          else                 w_state_nxt = S_DISCARD;
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // Branch seen while the PC cannot move yet: apply it at the next advance
      if (w_branch && !w_advance) begin
        w_pend_nxt = 1'b1;
        w_ptgt_nxt = branch_target_address_i;
      end else begin
        w_ptgt_nxt = r_ptgt;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_buf        <= NOP_INST;
      r_pend       <= 1'b0;
      r_ptgt       <= 32'h0000_0000;
      r_stale_addr <= 32'h0000_0000;
      r_adel       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_buf        <= w_buf_nxt;
      r_pend       <= w_pend_nxt;
      r_ptgt       <= w_ptgt_nxt;
      r_stale_addr <= w_stale_nxt;
      r_adel       <= w_adel_nxt;
    end
  end

  assign iram.iram_req_o  = ((r_state == S_REQ) && !w_misalign) || (r_state == S_DISCARD);
  assign iram.iram_addr_o = (r_state == S_DISCARD) ? r_stale_addr : w_fetch_addr;
  assign stallreq_o       = (r_state != S_VALID);
  assign pc_o             = r_pc;
  assign inst_o           = (r_state == S_VALID) ? r_buf : NOP_INST;
  assign excepttype_o     = r_adel ? ADEL_MASK : 32'h0000_0000;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory slave with programmable ack delay, per-cycle model checks.
`timescale 1ns/1ps
module tb_if_fetch_unit;

`ifdef IF_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_tgt;
  logic        stallreq_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] excepttype_o;

  int          ack_delay;
  logic        ack_block;
  int          wait_cnt;

  int          total = 0;
  int          bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  int          len_log[$];

  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;
  int          req_len;

  if_fetch_unit_if bus();

  if_fetch_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag),
    .branch_target_address_i (branch_tgt),
    .stallreq_o              (stallreq_o),
    .iram                    (bus.master),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .excepttype_o            (excepttype_o)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word for every address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return (MIS_EN && pc[1:0] != 2'b00) ? 32'h0000_0000 : mem_word(pc);
  endfunction

  function automatic logic [31:0] exp_exc(input logic [31:0] pc, input logic sreq);
    return (MIS_EN && !sreq && pc[1:0] != 2'b00) ? 32'h0000_0010 : 32'h0000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Slave: acks after ack_delay waiting cycles unless blocked
  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 0;
    else if (bus.iram_req_o && !bus.iram_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign bus.iram_ack_i   = bus.iram_req_o && !ack_block && (wait_cnt >= ack_delay);
  assign bus.iram_rdata_i = bus.iram_ack_i ? mem_word(bus.iram_addr_o) : 32'hBAD0_BAD0;

  // Per-cycle compare against the model, plus bus-protocol and fetch-stream checks
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
      req_len  = 0;
    end else begin
      if (stallreq_o) chk("inst_bubble", inst_o, 32'h0000_0000);
      else            chk("inst_word", inst_o, exp_inst(pc_o));
      chk("excepttype", excepttype_o, exp_exc(pc_o, stallreq_o));
      if (prev_req && !prev_ack) begin
        chk("req_held", 32'(bus.iram_req_o), 32'd1);
        chk("addr_held", bus.iram_addr_o, prev_addr);
      end
      if (!stallreq_o && !stall[0] && !flush) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fetch_extra: pc_o=%h delivered, none expected", pc_o);
        end else begin
          chk("fetch_pc", pc_o, exp_q.pop_front());
        end
      end
      if (bus.iram_req_o) begin
        if (bus.iram_ack_i) begin
          req_log.push_back(bus.iram_addr_o);
          len_log.push_back(req_len + 1);
          req_len = 0;
        end else begin
          req_len++;
        end
      end
      prev_req  = bus.iram_req_o;
      prev_ack  = bus.iram_ack_i;
      prev_addr = bus.iram_addr_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 6'b000000; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; branch_tgt = 32'h0;
    ack_delay = 0; ack_block = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(bus.iram_req_o), 32'd0);
    chk("rst_stallreq", 32'(stallreq_o), 32'd1);
    chk("rst_pc", pc_o, 32'h0000_0000);
    chk("rst_inst", inst_o, 32'h0000_0000);
    chk("rst_exc", excepttype_o, 32'h0000_0000);
    exp_q.delete();
    req_log.delete();
    len_log.delete();
    rst = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_pc(input logic [31:0] pc, input logic sreq, input string tag);
    int  n;
    bit  found;
    n = 0;
    found = (pc_o == pc) && (stallreq_o == sreq);
    while (!found && n < 300) begin
      tick();
      n++;
      found = (pc_o == pc) && (stallreq_o == sreq);
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for pc_o=%h stallreq_o=%0d", tag, pc, sreq);
    end
  endtask

  task automatic wait_empty(input string tag, output int cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    cycles = n;
  endtask

  initial begin
    int cyc;
    #2;

    // Back-to-back fetch with ack in the request cycle
    do_reset();
    push_seq(32'h0, 4);
    wait_empty("basic_stream", cyc);
    chk("basic_cycles", 32'(cyc), 32'd9);
    if (req_log.size() >= 3) begin
      chk("addr_seq0", req_log[0], 32'h0000_0000);
      chk("addr_seq1", req_log[1], 32'h0000_0004);
      chk("addr_seq2", req_log[2], 32'h0000_0008);
    end else begin
      chk("addr_seq_count", 32'(req_log.size()), 32'd3);
    end

    // Ack delayed by three cycles
    do_reset();
    ack_delay = 3;
    push_seq(32'h0, 2);
    wait_empty("slow_stream", cyc);
    if (len_log.size() >= 2) begin
      chk("req_len0", 32'(len_log[0]), 32'd4);
      chk("req_len1", 32'(len_log[1]), 32'd4);
    end else begin
      chk("req_len_count", 32'(len_log.size()), 32'd2);
    end

    // Pipeline stall holds the presented word
    do_reset();
    stall = 6'b000111;
    wait_pc(32'h0, 1'b0, "stall_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", pc_o, 32'h0000_0000);
      chk("stall_inst", inst_o, 32'h1357_9BDF);
      chk("stall_noreq", 32'(bus.iram_req_o), 32'd0);
    end
    stall = 6'b000000;
    push_seq(32'h0, 2);
    wait_empty("stall_stream", cyc);

    // Branch at 0x10 resolved while IF holds 0x14
    do_reset();
    push_seq(32'h0, 6);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_0104);
    wait_pc(32'h14, 1'b0, "br_valid_wait");
    branch_flag = 1'b1; branch_tgt = 32'h0000_0100;
    tick();
    branch_flag = 1'b0;
    wait_empty("br_valid_stream", cyc);

    // Same branch while 0x14 is still being fetched
    do_reset();
    ack_delay = 2;
    push_seq(32'h0, 6);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h0000_0104);
    wait_pc(32'h14, 1'b1, "br_req_wait");
    branch_flag = 1'b1; branch_tgt = 32'h0000_0100;
    tick();
    branch_flag = 1'b0;
    wait_empty("br_req_stream", cyc);

    // Flush while the request for 0x40 is outstanding
    do_reset();
    push_seq(32'h0, 16);
    wait_pc(32'h3C, 1'b0, "flush_wait");
    ack_block = 1'b1;
    tick();
    flush = 1'b1; new_pc = 32'h0000_0020;
    req_log.delete();
    tick();
    flush = 1'b0;
    chk("discard_pc", pc_o, 32'h0000_0020);
    chk("discard_addr", bus.iram_addr_o, 32'h0000_0040);
    chk("discard_req", 32'(bus.iram_req_o), 32'd1);
    chk("discard_stallreq", 32'(stallreq_o), 32'd1);
    tick();
    tick();
    ack_block = 1'b0;
    push_seq(32'h20, 3);
    wait_empty("flush_stream", cyc);
    if (req_log.size() >= 2) begin
      chk("stale_ack_addr", req_log[0], 32'h0000_0040);
      chk("redirect_addr", req_log[1], 32'h0000_0020);
    end else begin
      chk("flush_req_count", 32'(req_log.size()), 32'd2);
    end

    // PC wraps from FFFF_FFFC to 0; flush overrides stall
    do_reset();
    stall = 6'b000111;
    wait_pc(32'h0, 1'b0, "wrap_wait");
    flush = 1'b1; new_pc = 32'hFFFF_FFF8;
    req_log.delete();
    tick();
    flush = 1'b0;
    stall = 6'b000000;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    wait_empty("wrap_stream", cyc);
    if (req_log.size() >= 3) chk("wrap_addr", req_log[2], 32'h0000_0000);
    else                     chk("wrap_req_count", 32'(req_log.size()), 32'd3);

`ifdef IF_MISALIGN_EXC_EN
    // Misaligned branch target raises the fetch address error
    do_reset();
    push_seq(32'h0, 6);
    exp_q.push_back(32'h0000_0102);
    wait_pc(32'h14, 1'b0, "mis_wait");
    branch_flag = 1'b1; branch_tgt = 32'h0000_0102;
    tick();
    branch_flag = 1'b0;
    chk("mis_noreq", 32'(bus.iram_req_o), 32'd0);
    tick();
    chk("mis_inst", inst_o, 32'h0000_0000);
    chk("mis_exc", excepttype_o, 32'h0000_0010);
    chk("mis_stallreq", 32'(stallreq_o), 32'd0);
    wait_empty("mis_stream", cyc);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
